// File: rtl/ps2_key_event.sv
// ---------------------------------------------------------------------------
// ps2_key_event
//
// Purpose:
//   Sits behind the PS/2 byte receiver and turns the raw scan-code stream
//   into arrow-key events for the game control logic. It parses the E0
//   (extended) and F0 (break) prefixes and tracks which of the four arrow
//   keys are held. It also generates its own cycle-counted auto-repeat. The
//   keyboard's typematic repeat (a repeated make of a held key) is absorbed
//   without effect, so repeat timing depends only on the parameters below.
//
// Parameters:
//   REPEAT_DELAY  cycles from a make to the first repeat pulse (>= 2)
//   REPEAT_RATE   cycles between later repeat pulses (>= 2)
//   TIMEOUT       cycles a pending prefix waits for its next byte before it
//                 is dropped
//
// Ports:
//   i_clk         system clock
//   i_rst_n       asynchronous active-low reset
//   i_byte        scan-code byte, meaningful only while i_byte_valid = 1
//   i_byte_valid  one-cycle strobe per received byte; back-to-back strobes
//                 are allowed and every one is processed
//   o_held        level, one bit per held key: [3]=up [2]=down [1]=left
//                 [0]=right
//   o_move        one-cycle pulses, same bit order, on make and on each
//                 auto-repeat
//   o_release     one-cycle pulse on the break of a held key
//   o_busy        high while a prefix is pending (parser not idle)
//
// Handshake: there is no back-pressure. A byte is consumed on every clock
// edge where i_byte_valid is high. Every event output is registered, so it
// appears in the cycle after the strobe that resolves it.
// ---------------------------------------------------------------------------
module ps2_key_event #(
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000,
    parameter int TIMEOUT      = 1_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_byte,
    input  logic       i_byte_valid,
    output logic [3:0] o_held,
    output logic [3:0] o_move,
    output logic [3:0] o_release,
    output logic       o_busy
);

    // -----------------------------------------------------------------------
    // Counter sizing
    // -----------------------------------------------------------------------
    localparam int MAX_PERIOD = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W      = (MAX_PERIOD > 1) ? $clog2(MAX_PERIOD) : 1;
    localparam int TO_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE - 1);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    // -----------------------------------------------------------------------
    // Prefix parser state
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXT  = 2'd1,
        S_BRK  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   tcnt_q,  tcnt_d;

    // Key tracking state
    logic [3:0]        held_q,  held_d;
    logic [3:0]        move_q,  move_d;
    logic [3:0]        rel_q,   rel_d;
    logic [CNT_W-1:0]  cnt_q [4];
    logic [CNT_W-1:0]  cnt_d [4];

    // Events resolved by the current strobe (one-hot or zero)
    logic [3:0]        make_vec;
    logic [3:0]        brk_vec;

    // Decoded byte
    logic              is_ext;
    logic              is_brk;
    logic [3:0]        key_hit;

    // -----------------------------------------------------------------------
    // Byte decode. The keypad codes are the same with or without E0, so the
    // key decode ignores the prefix. Anything unrecognised (AA, FA, EE, E1
    // included) decodes to no key and resolves to nothing.
    // -----------------------------------------------------------------------
    assign is_ext = (i_byte == CODE_EXT);
    assign is_brk = (i_byte == CODE_BRK);

    always_comb begin
        key_hit = '0;
        case (i_byte)
            8'h75:   key_hit = 4'b1000;  // up
            8'h72:   key_hit = 4'b0100;  // down
            8'h6B:   key_hit = 4'b0010;  // left
            8'h74:   key_hit = 4'b0001;  // right
            default: key_hit = '0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Parser next state. A strobe always clears the timeout counter. If a
    // strobe arrives on the last timeout cycle, the byte is processed and the
    // timeout does not apply. When a pending prefix expires, the parser
    // returns to idle without producing any event.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        make_vec = '0;
        brk_vec  = '0;

        if (i_byte_valid) begin
            tcnt_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (is_ext) begin
                        state_d = S_EXT;
                    end else if (is_brk) begin
                        state_d = S_BRK;
                    end else begin
                        make_vec = key_hit;
                    end
                end
                S_EXT: begin
                    if (is_ext) begin
                        state_d = S_EXT;
                    end else if (is_brk) begin
                        state_d = S_BRK;
                    end else begin
                        make_vec = key_hit;
                        state_d  = S_IDLE;
                    end
                end
                S_BRK: begin
                    // Further prefixes after F0 are absorbed.
                    if (!is_ext && !is_brk) begin
                        brk_vec = key_hit;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else if (state_q != S_IDLE) begin
            if (tcnt_q == TO_LAST) begin
                state_d = S_IDLE;
                tcnt_d  = '0;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Per-key held / repeat logic. The branch order sets priority:
    //   1. A break of a held key wins over an expiring counter, so only the
    //      release pulse appears.
    //   2. A make of a key that is not held starts its delay.
    //   3. A held key counts down and pulses whenever its counter reads 0.
    //      A typematic make of a held key lands here and does not disturb
    //      the repeat phase.
    // A key that is not held keeps its counter at 0, so nothing underflows.
    // -----------------------------------------------------------------------
    always_comb begin
        held_d = held_q;
        move_d = '0;
        rel_d  = '0;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (brk_vec[i]) begin
                if (held_q[i]) begin
                    held_d[i] = 1'b0;
                    rel_d[i]  = 1'b1;
                    cnt_d[i]  = '0;
                end
            end else if (make_vec[i] && !held_q[i]) begin
                held_d[i] = 1'b1;
                move_d[i] = 1'b1;
                cnt_d[i]  = DELAY_LOAD;
            end else if (held_q[i]) begin
                if (cnt_q[i] == '0) begin
                    move_d[i] = 1'b1;
                    cnt_d[i]  = RATE_LOAD;
                end else begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            tcnt_q  <= '0;
            held_q  <= '0;
            move_q  <= '0;
            rel_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            held_q  <= held_d;
            move_q  <= move_d;
            rel_q   <= rel_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign o_held    = held_q;
    assign o_move    = move_q;
    assign o_release = rel_q;
    assign o_busy    = (state_q != S_IDLE);

endmodule
